forward_ctrl: RTL and testbench

FORWARD_CTRL -- requirements
Module: forward_ctrl

---
 rtl/forward_ctrl_pkg.sv | 35 +++
 rtl/forward_ctrl_if.sv | 31 +++
 rtl/fwd_stage_reg.sv | 17 +
 rtl/forward_ctrl.sv | 77 +++++++
 tb/tb_forward_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/forward_ctrl_pkg.sv
// Shared encodings and the per-stage instruction record for the forwarding/hazard unit.
// Records carry register fields at REC_AW bits; narrower REG_AW values are zero-extended.
package forward_ctrl_pkg;

  localparam int REC_AW = 8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rs1;
    logic [REC_AW-1:0] rs2;
    logic [REC_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  // True when a stage will write rs with a usable result (x0 never counts).
  function automatic logic produces(input stage_rec_t s, input logic [REC_AW-1:0] rs);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input stage_rec_t ex, input stage_rec_t mem,
                                         input stage_rec_t wb, input logic [REC_AW-1:0] rs);
    if (!ex.valid)            return FWD_REG;
    else if (produces(mem, rs)) return FWD_MEM;
    else if (produces(wb, rs))  return FWD_WB;
    else                        return FWD_REG;
  endfunction

endpackage

// File: rtl/forward_ctrl_if.sv
// ID-side request and EX-side forwarding/stall response bundle.
interface forward_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, ex_flush,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, ex_flush,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_stage_reg.sv
// One pipeline stage record: loads the incoming record or a bubble, async-cleared.
module fwd_stage_reg
  import forward_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  stage_rec_t d,
  output stage_rec_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= BUBBLE;
    else        q <= load ? d : BUBBLE;
  end

endmodule

// File: rtl/forward_ctrl.sv
// EX/MEM/WB record tracking with operand-forward selects, load-use stall and a
// saturating stall counter.
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           rst_n,
  forward_ctrl_if.slave bus
);

  localparam int STAGES = 3;

  stage_rec_t [STAGES-1:0] stg_d, stg_q;
  logic       [STAGES-1:0] stg_ld;
  stage_rec_t              id_rec, ex_q, mem_q, wb_q;
  logic                    stall, hit1, hit2;
  logic       [CNT_W-1:0]  cnt;
  logic       [1:0]        sel_a, sel_b;

  // Unused source fields are zeroed so they can never match a producer;
  // this is what keeps a non-reading instruction from forwarding a load.
  always_comb begin
    id_rec          = BUBBLE;
    id_rec.valid    = bus.id_valid;
    id_rec.rs1      = bus.id_use_rs1 ? REC_AW'(bus.id_rs1) : '0;
    id_rec.rs2      = bus.id_use_rs2 ? REC_AW'(bus.id_rs2) : '0;
    id_rec.rd       = REC_AW'(bus.id_rd);
    id_rec.regwrite = bus.id_regwrite;
    id_rec.memread  = bus.id_memread;
  end

  assign ex_q  = stg_q[0];
  assign mem_q = stg_q[1];
  assign wb_q  = stg_q[2];

  assign hit1  = bus.id_use_rs1 && (REC_AW'(bus.id_rs1) == ex_q.rd);
  assign hit2  = bus.id_use_rs2 && (REC_AW'(bus.id_rs2) == ex_q.rd);
  assign stall = !bus.ex_flush && bus.id_valid && ex_q.valid && ex_q.memread &&
                 (ex_q.rd != '0) && (hit1 || hit2);

  assign stg_d  = {mem_q, ex_q, id_rec};
  assign stg_ld = {1'b1, 1'b1, bus.id_valid && !stall && !bus.ex_flush};

  for (genvar g = 0; g < STAGES; g++) begin : g_stg
    fwd_stage_reg u_stg (
      .clk  (clk),
      .rst_n(rst_n),
      .load (stg_ld[g]),
      .d    (stg_d[g]),
      .q    (stg_q[g])
    );
  end

  // Selects depend only on registered records; no ID-to-select path.
  assign sel_a = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs1);
  assign sel_b = fwd_sel(ex_q, mem_q, wb_q, ex_q.rs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (stall && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

  assign bus.fwd_a_sel   = sel_a;
  assign bus.fwd_b_sel   = sel_b;
  assign bus.stall       = stall;
  assign bus.stall_count = cnt;

  a_no_rsvd: assert property (@(posedge clk) disable iff (!rst_n)
    sel_a != 2'b11 && sel_b != 2'b11);

  a_no_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
    (sel_a == FWD_MEM || sel_b == FWD_MEM) |-> !mem_q.memread);

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed pipeline scenarios plus random instruction streams against an
// instruction-level model of the EX/MEM/WB pipeline.
module tb_forward_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  forward_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
  forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit v, u1, u2, rw, mr;
    int rs1, rs2, rd;
  } ins_t;

  ins_t ex_m, mem_m, wb_m, cur;
  bit   flush_m;
  int   cnt_m;
  int   errors = 0;
  int   checks = 0;

  function automatic ins_t nop();
    ins_t i;
    i = '{v:0, u1:0, u2:0, rw:0, mr:0, rs1:0, rs2:0, rd:0};
    return i;
  endfunction

  function automatic ins_t alu(int rd, int rs1, int rs2);
    ins_t i;
    i = '{v:1, u1:1, u2:1, rw:1, mr:0, rs1:rs1, rs2:rs2, rd:rd};
    return i;
  endfunction

  function automatic ins_t ld(int rd, int rs1);
    ins_t i;
    i = '{v:1, u1:1, u2:0, rw:1, mr:1, rs1:rs1, rs2:0, rd:rd};
    return i;
  endfunction

  // Load-use hazard: the instruction in ID reads the destination of a load in EX.
  function automatic bit exp_stall();
    if (flush_m || !cur.v || !ex_m.v || !ex_m.mr || ex_m.rd == 0) return 1'b0;
    return (cur.u1 && cur.rs1 == ex_m.rd) || (cur.u2 && cur.rs2 == ex_m.rd);
  endfunction

  // Youngest older writer of rs wins; x0 is never forwarded.
  function automatic logic [1:0] exp_sel(bit used, int rs);
    if (!ex_m.v || !used || rs == 0) return 2'd0;
    if (mem_m.v && mem_m.rw && mem_m.rd == rs) return 2'd2;
    if (wb_m.v && wb_m.rw && wb_m.rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic drive(input ins_t i, input bit fl);
    cur             = i;
    flush_m         = fl;
    bus.id_valid    = i.v;
    bus.id_use_rs1  = i.u1;
    bus.id_use_rs2  = i.u2;
    bus.id_rs1      = AW'(i.rs1);
    bus.id_rs2      = AW'(i.rs2);
    bus.id_rd       = AW'(i.rd);
    bus.id_regwrite = i.rw;
    bus.id_memread  = i.mr;
    bus.ex_flush    = fl;
    #1;
  endtask

  task automatic tick();
    bit s;
    s = exp_stall();
    @(posedge clk);
    wb_m  = mem_m;
    mem_m = ex_m;
    ex_m  = (cur.v && !s && !flush_m) ? cur : nop();
    if (s && cnt_m < CMAX) cnt_m++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(nop(), 1'b0);
    rst_n = 1'b0;
    ex_m = nop(); mem_m = nop(); wb_m = nop(); cnt_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(ld(5, 5), 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", bus.stall); end
    checks++; if (bus.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL rst_sel_a: got %b exp 00", bus.fwd_a_sel); end
    checks++; if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL rst_sel_b: got %b exp 00", bus.fwd_b_sel); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", bus.stall_count); end
    @(negedge clk);
    do_reset();
    checks++; if (bus.stall !== 1'b0 || bus.fwd_a_sel !== 2'b00) begin
      errors++; $display("FAIL post_rst_idle: got stall=%b a=%b exp 0/00", bus.stall, bus.fwd_a_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(ld(5, 1), 1'b0); tick();
    drive(alu(6, 5, 1), 1'b0);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", bus.stall); end
    tick();
    checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL lu_count: got %0d exp 1", bus.stall_count); end
    drive(alu(6, 5, 1), 1'b0);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_no_second_stall: got %b exp 0", bus.stall); end
    tick();
    drive(nop(), 1'b0);
    checks++; if (bus.fwd_a_sel !== 2'b01) begin errors++; $display("FAIL lu_sel_a: got %b exp 01", bus.fwd_a_sel); end
    checks++; if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL lu_sel_b: got %b exp 00", bus.fwd_b_sel); end
    checks++; if (bus.stall_count !== 4'd1) begin errors++; $display("FAIL lu_count_hold: got %0d exp 1", bus.stall_count); end
  endtask

  task automatic test_mem_fwd();
    do_reset();
    drive(alu(3, 1, 2), 1'b0); tick();
    drive(alu(4, 3, 3), 1'b0);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mem_stall: got %b exp 0", bus.stall); end
    tick();
    drive(nop(), 1'b0);
    checks++; if (bus.fwd_a_sel !== 2'b10) begin errors++; $display("FAIL mem_sel_a: got %b exp 10", bus.fwd_a_sel); end
    checks++; if (bus.fwd_b_sel !== 2'b10) begin errors++; $display("FAIL mem_sel_b: got %b exp 10", bus.fwd_b_sel); end
  endtask

  task automatic test_mem_priority();
    do_reset();
    drive(alu(3, 1, 2), 1'b0); tick();
    drive(alu(3, 1, 2), 1'b0); tick();
    drive(alu(7, 3, 0), 1'b0); tick();
    drive(nop(), 1'b0);
    checks++; if (bus.fwd_a_sel !== 2'b10) begin errors++; $display("FAIL prio_sel_a: got %b exp 10", bus.fwd_a_sel); end
    checks++; if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL prio_sel_b: got %b exp 00", bus.fwd_b_sel); end
    tick();
    checks++; if (bus.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL prio_idle: got %b exp 00", bus.fwd_a_sel); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(ld(0, 1), 1'b0); tick();
    drive(alu(6, 0, 0), 1'b0);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b exp 0", bus.stall); end
    tick();
    drive(nop(), 1'b0);
    checks++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin
      errors++; $display("FAIL x0_sel: got a=%b b=%b exp 00/00", bus.fwd_a_sel, bus.fwd_b_sel); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(ld(5, 1), 1'b0); tick();
    drive(alu(6, 5, 1), 1'b1);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b exp 0", bus.stall); end
    tick();
    drive(alu(6, 5, 1), 1'b0);
    checks++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin
      errors++; $display("FAIL fl_bubble_sel: got a=%b b=%b exp 00/00", bus.fwd_a_sel, bus.fwd_b_sel); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL fl_after_stall: got %b exp 0", bus.stall); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL fl_count: got %0d exp 0", bus.stall_count); end
  endtask

  // A chain of loads, each reading the previous one's destination, stalls once per link.
  task automatic test_saturation();
    int prd, nrd;
    do_reset();
    prd = 5;
    drive(ld(prd, 0), 1'b0); tick();
    for (int k = 0; k < CMAX + 1; k++) begin
      nrd = (prd == 5) ? 7 : 5;
      drive(ld(nrd, prd), 1'b0);
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sat_stall_%0d: got %b exp 1", k, bus.stall); end
      tick();
      checks++; if (int'(bus.stall_count) !== ((k + 1 > CMAX) ? CMAX : k + 1)) begin
        errors++; $display("FAIL sat_count_%0d: got %0d exp %0d", k, bus.stall_count, (k + 1 > CMAX) ? CMAX : k + 1); end
      drive(ld(nrd, prd), 1'b0); tick();
      prd = nrd;
    end
    nrd = (prd == 5) ? 7 : 5;
    drive(ld(nrd, prd), 1'b0);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b exp 1", bus.stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b exp 0", bus.stall); end
    checks++; if (bus.stall_count !== 4'd0) begin errors++; $display("FAIL midrst_count: got %0d exp 0", bus.stall_count); end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_random();
    ins_t i;
    int   t;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      t = $urandom_range(0, 3);
      case (t)
        0: i = alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        1: i = ld($urandom_range(0, 3), $urandom_range(0, 3));
        2: begin i = alu(0, $urandom_range(0, 3), $urandom_range(0, 3)); i.rw = 0; i.rd = $urandom_range(0, 3); end
        default: begin
          i = alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
          i.u1 = $urandom_range(0, 1); i.u2 = $urandom_range(0, 1);
        end
      endcase
      i.v = ($urandom_range(0, 9) < 8);
      drive(i, $urandom_range(0, 9) == 0);
      checks++; if (bus.stall !== exp_stall()) begin
        errors++; $display("FAIL rnd_stall_%0d: got %b exp %b", n, bus.stall, exp_stall()); end
      checks++; if (bus.fwd_a_sel !== exp_sel(ex_m.u1, ex_m.rs1)) begin
        errors++; $display("FAIL rnd_sel_a_%0d: got %b exp %b", n, bus.fwd_a_sel, exp_sel(ex_m.u1, ex_m.rs1)); end
      checks++; if (bus.fwd_b_sel !== exp_sel(ex_m.u2, ex_m.rs2)) begin
        errors++; $display("FAIL rnd_sel_b_%0d: got %b exp %b", n, bus.fwd_b_sel, exp_sel(ex_m.u2, ex_m.rs2)); end
      checks++; if (int'(bus.stall_count) !== cnt_m) begin
        errors++; $display("FAIL rnd_count_%0d: got %0d exp %0d", n, bus.stall_count, cnt_m); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_fwd();
    test_mem_priority();
    test_x0();
    test_flush();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
